mem_io_system: RTL and testbench

- Memory and I/O subsystem directly downstream of the 8-bit multicycle CPU core.
- Consumes the CPU's memAdr/memWD/memEnable and returns memRD.
- Decodes a single 256-byte address space into:
  - 240 bytes of data RAM;
  - memory-mapped LED and switch registers;
  - a free-running cycle counter;
  - a buffered 8N1 UART transmitter.

---
 rtl/mem_io_system.sv | 144 ++++++++++++++
 tb/tb_mem_io_system.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_system.sv
// Memory and I/O subsystem for the 8-bit multicycle CPU: data RAM, LEDs, switches,
// cycle counter and a FIFO-buffered 8N1 UART transmitter on one 256-byte map.
module mem_io_system #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] memAdr,
    input  logic [7:0] memWD,
    input  logic       memEnable,
    output logic [7:0] memRD,
    input  logic [7:0] switches,
    output logic [7:0] leds,
    output logic       uart_tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]    ram [0:239];
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [7:0]    sw_meta, sw_sync, cycle_cnt, shreg;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          overflow, fifo_empty, fifo_full, tx_busy;
    logic          push_req, push_ok, pop;
    logic          wr_ram, wr_led, wr_stat, wr_cnt;
    tx_state_t     state;

    assign wr_ram   = memEnable && (memAdr < 8'hF0);
    assign wr_led   = memEnable && (memAdr == 8'hF0);
    assign push_req = memEnable && (memAdr == 8'hF2);
    assign wr_stat  = memEnable && (memAdr == 8'hF3);
    assign wr_cnt   = memEnable && (memAdr == 8'hF4);

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign tx_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (wr_ram) ram[memAdr] <= memWD;
    end

    // A push into a full FIFO with a pop lands in the slot being vacated this edge.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= memWD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds      <= 8'h00;
            sw_meta   <= 8'h00;
            sw_sync   <= 8'h00;
            cycle_cnt <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (wr_led) leds <= memWD;
            if (wr_cnt) cycle_cnt <= memWD;
            else        cycle_cnt <= cycle_cnt + 8'd1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            else if (wr_stat)                  overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shreg    <= fifo_mem[rd_ptr[PW-1:0]];
                        baud_cnt <= BIT_LAST;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LAST;
                        bit_idx  <= 3'd0;
                        uart_tx  <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) state <= IDLE;
                    else                baud_cnt <= baud_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        memRD = 8'h00;
        if (memAdr < 8'hF0) begin
            memRD = ram[memAdr];
        end else begin
            case (memAdr)
                8'hF0:   memRD = leds;
                8'hF1:   memRD = sw_sync;
                8'hF3:   memRD = {4'b0, overflow, tx_busy, fifo_empty, fifo_full};
                8'hF4:   memRD = cycle_cnt;
                default: memRD = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_system.sv
// Directed bench for mem_io_system: register map, synchronizer, counter, UART
// framing, FIFO overflow / full-with-pop, and reset during a frame.
module tb_mem_io_system;
    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] memAdr, memWD, memRD, switches, leds;
    logic       memEnable, uart_tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;

    mem_io_system #(.CLKS_PER_BIT(BIT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .memAdr(memAdr), .memWD(memWD),
        .memEnable(memEnable), .memRD(memRD), .switches(switches),
        .leds(leds), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Serial line receiver: samples mid-bit, keeps only frames with a valid stop bit.
    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (!uart_tx) begin
                mon_active = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % BIT == BIT/2) && mon_cnt > BIT && mon_cnt < 9*BIT)
                mon_sh = {uart_tx, mon_sh[7:1]};
            else if (mon_cnt == 9*BIT + BIT/2) begin
                if (uart_tx) rx_q.push_back(mon_sh);
                mon_active = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        memAdr = a;
        #1;
        d = memRD;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        memAdr = a;
        memWD = d;
        memEnable = 1'b1;
        @(negedge clk);
        memEnable = 1'b0;
    endtask

    task automatic push_burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] vals [6];
        vals = '{b0, b1, b2, b3, b4, b5};
        @(negedge clk);
        memAdr = 8'hF2;
        memEnable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            memWD = vals[i];
            @(negedge clk);
        end
        memEnable = 1'b0;
    endtask

    logic [7:0] d;
    logic [9:0] frame;
    logic       found;

    initial begin
        reset = 1'b0;
        memAdr = 8'h00;
        memWD = 8'h00;
        memEnable = 1'b0;
        switches = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", {7'b0, uart_tx}, 8'h01);
        chk("rst_leds", leds, 8'h00);
        #2 reset = 1'b1;
        @(negedge clk);

        for (int a = 8'hF0; a <= 8'hFF; a++) begin
            rd(8'(a), d);
            if (a == 8'hF3)      chk("rst_status", d, 8'h02);
            else if (a != 8'hF4) chk($sformatf("rst_rd_%02h", a), d, 8'h00);
        end

        wr(8'h10, 8'h5A);
        wr(8'hEF, 8'hA5);
        wr(8'hF0, 8'h3C);
        chk("leds_3c", leds, 8'h3C);
        rd(8'h10, d); chk("ram_10", d, 8'h5A);
        rd(8'hEF, d); chk("ram_ef", d, 8'hA5);
        rd(8'hF0, d); chk("led_rd", d, 8'h3C);
        wr(8'hF1, 8'hFF);
        rd(8'hF1, d); chk("sw_wr_ignored", d, 8'h00);

        switches = 8'h81;
        rd(8'hF1, d); chk("sw_lat0", d, 8'h00);
        @(negedge clk);
        rd(8'hF1, d); chk("sw_lat1", d, 8'h00);
        @(negedge clk);
        rd(8'hF1, d); chk("sw_lat2", d, 8'h81);

        wr(8'hF4, 8'hFE);
        rd(8'hF4, d); chk("cnt_fe", d, 8'hFE);
        @(negedge clk);
        rd(8'hF4, d); chk("cnt_ff", d, 8'hFF);
        @(negedge clk);
        rd(8'hF4, d); chk("cnt_wrap", d, 8'h00);

        // Single byte 0x55: frame bits start, data LSB first, stop.
        wr(8'hF2, 8'h55);
        chk("tx_pre_start", {7'b0, uart_tx}, 8'h01);
        rd(8'hF3, d); chk("stat_queued", d, 8'h00);
        frame = {1'b1, 8'h55, 1'b0};
        memAdr = 8'hF3;
        for (int c = 0; c < 10*BIT; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("tx_c%0d", c), {7'b0, uart_tx}, {7'b0, frame[c/BIT]});
            if (c % BIT == 0) chk($sformatf("busy_c%0d", c), {7'b0, memRD[2]}, 8'h01);
        end
        @(negedge clk);
        rd(8'hF3, d); chk("stat_after_frame", d, 8'h02);

        // Run A: 6 back-to-back pushes, 6th dropped, 5 frames in order.
        rx_q.delete();
        push_burst(8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h77);
        rd(8'hF3, d);
        chk("ovf_set", d & 8'h0B, 8'h09);
        chk("ovf_busy", {7'b0, d[2]}, 8'h01);
        wr(8'hF3, 8'h00);
        rd(8'hF3, d); chk("ovf_clear", d & 8'h0B, 8'h01);
        for (int i = 0; i < 1200 && rx_q.size() < 5; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("rxA_count", 8'(rx_q.size()), 8'd5);
        chk("rxA_0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'hA1);
        chk("rxA_1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'h3C);
        chk("rxA_2", rx_q.size() > 2 ? rx_q[2] : 8'hxx, 8'h0F);
        chk("rxA_3", rx_q.size() > 3 ? rx_q[3] : 8'hxx, 8'hF0);
        chk("rxA_4", rx_q.size() > 4 ? rx_q[4] : 8'hxx, 8'h96);

        // Run B: push into full FIFO on the pop edge, then reset in the 3rd frame.
        rx_q.delete();
        push_burst(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
        wr(8'hF3, 8'h00);
        memAdr = 8'hF3;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (memRD[2] == 1'b0) found = 1'b1;
        end
        chk("poll_idle", {7'b0, found}, 8'h01);
        memAdr = 8'hF2;
        memWD = 8'hC3;
        memEnable = 1'b1;
        @(negedge clk);
        memEnable = 1'b0;
        rd(8'hF3, d); chk("full_pop_push", d & 8'h0B, 8'h01);
        for (int i = 0; i < 1000 && rx_q.size() < 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("pre_rst_tx", {7'b0, uart_tx}, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", {7'b0, uart_tx}, 8'h01);
        chk("midrst_leds", leds, 8'h00);
        rd(8'hF1, d); chk("midrst_sw", d, 8'h00);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (400) @(negedge clk);
        chk("rxB_count", 8'(rx_q.size()), 8'd2);
        chk("rxB_0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h31);
        chk("rxB_1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'h32);
        chk("post_rst_tx", {7'b0, uart_tx}, 8'h01);
        rd(8'hF3, d); chk("post_rst_status", d, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
